top: RTL and testbench

// Self-contained SPI daisy-chain demonstrator. An internal SPI master serially shifts
// a fixed byte through NUM_SLAVES cascaded 8-bit SPI shift-register slaves.
// The master collects the byte back from the end of the chain on MISO.
// The returned byte appears on dout, and done pulses once per transaction.

---
 rtl/spi_chain_pkg.sv | 18 +
 rtl/spi_chain_slave_sr.sv | 25 ++
 rtl/spi_chain.sv | 132 +++++++++++++
 tb/tb_top.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/spi_chain_pkg.sv
// Shared types and sizing helpers for the SPI daisy-chain demonstrator.
package spi_chain_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Master shifts one byte per slave plus its own byte out of the chain.
    function automatic int unsigned bits_total(input int unsigned n);
        return BYTE_W * (n + 1);
    endfunction

endpackage

// File: rtl/spi_chain_slave_sr.sv
// 8-bit SPI shift-register slave; shifts on the sclk rising-edge enable while selected.
module spi_slave_sr
    import spi_chain_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic sin,
    output logic sout
);

    logic [BYTE_W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (!cs_n && sclk_rise) begin
            sr <= {sr[BYTE_W-2:0], sin};
        end
    end

    assign sout = sr[BYTE_W-1];

endmodule

// File: rtl/spi_chain.sv
// SPI master that shifts TX_DATA through NUM_SLAVES cascaded slaves and returns it on dout.
module top
    import spi_chain_pkg::*;
#(
    parameter logic [BYTE_W-1:0] TX_DATA    = 8'hA5,
    parameter int unsigned       NUM_SLAVES = 2,
    parameter int unsigned       CLK_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    output logic [BYTE_W-1:0] dout,
    output logic              done
);

    localparam int unsigned B     = bits_total(NUM_SLAVES);
    localparam int unsigned BIT_W = $clog2(B);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t state, next_state;

    logic              tx_prev;
    logic              cs_n;
    logic              sclk;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] tx_sr;
    logic [BYTE_W-1:0] rx_sr;
    logic              mosi;
    logic              miso;
    logic [NUM_SLAVES:0] chain;

    logic start_c;
    logic half_end_c;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic last_bit_c;

    assign start_c     = tx_enable && !tx_prev && (state == IDLE);
    assign half_end_c  = (state == SHIFT) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sclk_rise_c = half_end_c && !sclk;
    assign sclk_fall_c = half_end_c && sclk;
    assign last_bit_c  = (bit_cnt == BIT_W'(B - 1));

    // MOSI is the MSB of the tx register; zeros fill in behind TX_DATA.
    assign mosi = tx_sr[BYTE_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_c) next_state = START;
            START:   next_state = SHIFT;
            SHIFT:   if (sclk_fall_c && last_bit_c) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Master datapath: SCLK divider, bit counter, tx/rx shift registers, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_prev <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            dout    <= '0;
            done    <= 1'b0;
        end else begin
            tx_prev <= tx_enable;
            done    <= 1'b0;
            case (state)
                START: begin
                    cs_n    <= 1'b0;
                    sclk    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    tx_sr   <= TX_DATA;
                end
                SHIFT: begin
                    if (half_end_c) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (sclk_rise_c) begin
                        rx_sr <= {rx_sr[BYTE_W-2:0], miso};
                    end
                    if (sclk_fall_c && !last_bit_c) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        tx_sr   <= {tx_sr[BYTE_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    dout <= rx_sr;
                    done <= 1'b1;
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign chain[0] = mosi;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        spi_slave_sr u_slave (
            .clk       (clk),
            .rst       (rst),
            .cs_n      (cs_n),
            .sclk_rise (sclk_rise_c),
            .sin       (chain[i]),
            .sout      (chain[i+1])
        );
    end

    // Sampled on the same edge the slaves shift, so this is the pre-shift MSB.
    assign miso = chain[NUM_SLAVES];

endmodule

// File: tb/tb_top.sv
// Directed bench for the SPI daisy-chain: default chain plus a one-slave 8'h3C variant.
module tb_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic       tx_enable1;
    logic [7:0] dout;
    logic [7:0] dout1;
    logic       done;
    logic       done1;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int log_n  = 0;
    logic mosi_log [64];
    logic miso_log [64];

    always #5 clk = ~clk;

    top dut (
        .clk       (clk),
        .rst       (rst),
        .tx_enable (tx_enable),
        .dout      (dout),
        .done      (done)
    );

    top #(.TX_DATA(8'h3C), .NUM_SLAVES(1), .CLK_DIV(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .tx_enable (tx_enable1),
        .dout      (dout1),
        .done      (done1)
    );

    always @(negedge clk) begin
        if (done) pulses++;
    end

    // Capture the MOSI/MISO levels the one-slave chain sees at each SCLK rise.
    always @(negedge clk) begin
        if (dut1.sclk_rise_c && log_n < 64) begin
            mosi_log[log_n] = dut1.mosi;
            miso_log[log_n] = dut1.miso;
            log_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until done rises on the chosen instance; -1 if the budget runs out.
    task automatic wait_done(input bit sel, input int limit, output int cyc);
        int n;
        n = 0;
        cyc = -1;
        while (n < limit) begin
            tick(1);
            n++;
            if ((sel ? done1 : done) === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int p0;
        logic [7:0] tx1;
        tx1 = 8'h3C;
        rst = 1'b1;
        tx_enable = 1'b0;
        tx_enable1 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("rst_dout_%0d", i), 32'(dout), 32'h00);
            check($sformatf("rst_done_%0d", i), 32'(done), 32'h0);
            check($sformatf("rst_csn_%0d", i), 32'(dut.cs_n), 32'h1);
        end

        rst = 1'b0;
        tx_enable = 1'b1;
        p0 = pulses;
        wait_done(1'b0, 300, cyc);
        check("t2_latency", 32'(cyc), 32'd99);
        check("t2_dout", 32'(dout), 32'hA5);
        tick(1);
        check("t2_done_one_cycle", 32'(done), 32'h0);

        tick(500);
        check("t3_single_pulse", 32'(pulses - p0), 32'd1);
        check("t3_dout_hold", 32'(dout), 32'hA5);

        tx_enable = 1'b0;
        tick(1);
        tx_enable = 1'b1;
        wait_done(1'b0, 300, cyc);
        check("t4_latency", 32'(cyc), 32'd99);
        check("t4_dout", 32'(dout), 32'hA5);

        tx_enable = 1'b0;
        tick(1);
        tx_enable = 1'b1;
        tick(41);
        check("t5_in_shift", 32'(dut.state), 32'd2);
        p0 = pulses;
        rst = 1'b1;
        tx_enable = 1'b0;
        #1;
        check("t5_rst_dout", 32'(dout), 32'h00);
        check("t5_rst_done", 32'(done), 32'h0);
        check("t5_rst_csn", 32'(dut.cs_n), 32'h1);
        tick(2);
        rst = 1'b0;
        tick(150);
        check("t5_no_done", 32'(pulses - p0), 32'd0);
        check("t5_dout_zero", 32'(dout), 32'h00);
        tx_enable = 1'b1;
        wait_done(1'b0, 300, cyc);
        check("t5_restart_latency", 32'(cyc), 32'd99);
        check("t5_restart_dout", 32'(dout), 32'hA5);

        tx_enable1 = 1'b1;
        wait_done(1'b1, 300, cyc);
        check("t6_latency", 32'(cyc), 32'd67);
        check("t6_dout", 32'(dout1), 32'h3C);
        check("t6_rise_count", 32'(log_n), 32'd16);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t6_mosi_%0d", k), 32'(mosi_log[k]), 32'(tx1[7-k]));
            check($sformatf("t6_miso_stale_%0d", k), 32'(miso_log[k]), 32'h0);
            check($sformatf("t6_mosi_tail_%0d", k), 32'(mosi_log[k+8]), 32'h0);
            check($sformatf("t6_miso_delay_%0d", k), 32'(miso_log[k+8]), 32'(tx1[7-k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
